// File: rtl/iob_uart_rx_frontend_if.sv
// Byte stream handshake between the UART receive front-end and its consumer.
// The master drives data/valid, the slave answers with ready.
interface iob_uart_rx_frontend_if;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;

   modport master (
      output data_o,
      output valid_o,
      input  ready_i
   );

   modport slave (
      input  data_o,
      input  valid_o,
      output ready_i
   );
endinterface

// File: rtl/iob_uart_rx_frontend.sv
// UART receive front-end: rxd synchroniser, 8N1 deserialiser, byte FIFO.
// Optional macro IOB_UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit.
module iob_uart_rx_frontend #(
   parameter int FREQ   = 100000000,
   parameter int BAUD   = 115200,
   parameter int FIFO_W = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rxd_i,
   iob_uart_rx_frontend_if.master rx_if,
   output logic rts_o,
   output logic frame_err_o,
   output logic overrun_o,
   input  logic clr_i
);
   localparam int DIV   = (FREQ + BAUD / 2) / BAUD;
   localparam int CW    = $clog2(DIV + 1);
   localparam int DEPTH = 2 ** FIFO_W;
   localparam int LW    = FIFO_W + 1;
`ifdef IOB_UART_RX_MAJORITY_EN
   localparam int LATE  = 1;
`else
   localparam int LATE  = 0;
`endif
   localparam logic [CW-1:0] HALF_T   = CW'(DIV / 2 - 1 + LATE);
   localparam logic [CW-1:0] FULL_T   = CW'(DIV - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_HIGH = LW'(DEPTH - 1);

`ifdef IOB_UART_RX_MAJORITY_EN
   if (DIV < 4) begin : g_div_chk
      $error("majority sampling needs at least 4 clocks per bit");
   end
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT
   } state_t;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          rx;
   logic          bit_val;
`ifdef IOB_UART_RX_MAJORITY_EN
   logic          p1_q, p1_d;
   logic          p2_q, p2_d;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          ferr_q, ferr_d;
   logic          push;

   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        mem_d [DEPTH];
   logic [FIFO_W-1:0] wr_q, wr_d;
   logic [FIFO_W-1:0] rd_q, rd_d;
   logic [LW-1:0]     lvl_q, lvl_d;
   logic              ovr_q, ovr_d;
   logic              pop, full, acc, drop;

   assign rx = sync2_q;

   // Synchroniser chain and the bit decision seen by the FSM
   always_comb begin
      sync1_d = rxd_i;
      sync2_d = sync1_q;
`ifdef IOB_UART_RX_MAJORITY_EN
      p1_d    = rx;
      p2_d    = p1_q;
      bit_val = (rx & p1_q) | (rx & p2_q) | (p1_q & p2_q);
`else
      bit_val = rx;
`endif
   end

   // Frame FSM: start validation, LSB-first shift, stop check
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      ferr_d  = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_T) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = bit_val ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_T) begin
               cnt_d   = '0;
               shreg_d = {bit_val, shreg_q[7:1]};
               if (idx_q == 3'd7) state_d = S_STOP;
               else idx_d = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_T) begin
               cnt_d = '0;
               if (bit_val) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            if (rx) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping; a full FIFO still accepts a push when popped
   always_comb begin
      pop   = (lvl_q != '0) && rx_if.ready_i;
      full  = (lvl_q == LVL_FULL);
      acc   = push && (!full || pop);
      drop  = push && full && !pop;
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (acc) begin
         mem_d[wr_q] = shreg_q;
         wr_d        = wr_q + FIFO_W'(1);
      end
      if (pop) rd_d = rd_q + FIFO_W'(1);
      if (acc && !pop) lvl_d = lvl_q + LW'(1);
      else if (!acc && pop) lvl_d = lvl_q - LW'(1);
      if (drop) ovr_d = 1'b1;
      else if (clr_i) ovr_d = 1'b0;
      else ovr_d = ovr_q;
   end

   // Line synchroniser registers, idle-high after reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
`ifdef IOB_UART_RX_MAJORITY_EN
         p1_q    <= 1'b1;
         p2_q    <= 1'b1;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
`ifdef IOB_UART_RX_MAJORITY_EN
         p1_q    <= p1_d;
         p2_q    <= p2_d;
`endif
      end
   end

   // Frame FSM state and registered framing-error pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         ferr_q  <= ferr_d;
      end
   end

   // FIFO storage, pointers, level and sticky overrun
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
         ovr_q <= ovr_d;
      end
   end

   assign rx_if.data_o  = mem_q[rd_q];
   assign rx_if.valid_o = (lvl_q != '0);
   assign rts_o         = (lvl_q < LVL_HIGH);
   assign frame_err_o   = ferr_q;
   assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_iob_uart_rx_frontend.sv
// Randomised bench for iob_uart_rx_frontend against a byte-queue model.
// Also covers the directed framing, FIFO and reset scenarios.
module tb_iob_uart_rx_frontend;
   localparam int DIV = 10;
`ifdef IOB_UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int PUSH_OFS = 98 + MAJ;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic clr = 1'b0;
   logic rts, ferr, ovr;

   iob_uart_rx_frontend_if u_if ();

   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   bit s_rdy, s_clr, s_rst;

   logic [7:0] mq[$];
   bit m_ovr, m_ferr;
   bit pend_v, pend_ok;
   int pend_cyc;
   logic [7:0] pend_dat;

   iob_uart_rx_frontend #(
      .FREQ  (1000000),
      .BAUD  (100000),
      .FIFO_W(2)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rxd_i      (rxd),
      .rx_if      (u_if),
      .rts_o      (rts),
      .frame_err_o(ferr),
      .overrun_o  (ovr),
      .clr_i      (clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      s_rdy <= u_if.ready_i;
      s_clr <= clr;
      s_rst <= rst;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference: queue of bytes, push one frame time after the start bit
   initial begin : model
      bit drop;
      forever begin
         @(negedge clk);
         drop   = 1'b0;
         m_ferr = 1'b0;
         if (s_rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            pend_v = 1'b0;
         end else begin
            if (s_rdy && mq.size() > 0) void'(mq.pop_front());
            if (pend_v && cyc == pend_cyc) begin
               pend_v = 1'b0;
               if (!pend_ok) m_ferr = 1'b1;
               else if (mq.size() < 4) mq.push_back(pend_dat);
               else drop = 1'b1;
            end
            if (drop) m_ovr = 1'b1;
            else if (s_clr) m_ovr = 1'b0;
         end
         if (chk_en) begin
            chk("valid", 32'(u_if.valid_o), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("data", 32'(u_if.data_o), 32'(mq[0]));
            chk("rts", 32'(rts), 32'(mq.size() < 3));
            chk("ferr", 32'(ferr), 32'(m_ferr));
            chk("ovr", 32'(ovr), 32'(m_ovr));
         end
      end
   end

   task automatic send(input logic [7:0] b, input int stop_len,
                       input logic stop_v);
      pend_dat = b;
      pend_ok  = stop_v;
      pend_cyc = cyc + PUSH_OFS;
      pend_v   = 1'b1;
      rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
      rxd = stop_v;
      repeat (stop_len) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic watch(output logic [7:0] got, output int lat);
      int t0 = cyc;
      got = 8'h00;
      lat = -1;
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         if (u_if.valid_o) begin
            got = u_if.data_o;
            lat = cyc - t0 - 1;
            break;
         end
      end
   endtask

   task automatic send_cap(input logic [7:0] b, output logic [7:0] got,
                           output int lat);
      fork
         send(b, DIV, 1'b1);
         watch(got, lat);
      join
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk({tag, "_v"}, 32'(u_if.valid_o), 1);
      chk(tag, 32'(u_if.data_o), 32'(exp));
      u_if.ready_i = 1'b1;
      @(negedge clk);
      u_if.ready_i = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: cycle %0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] got;
      int lat, nf, nv;
      bit done;
      u_if.ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(u_if.valid_o), 0);
      chk("rst_data", 32'(u_if.data_o), 0);
      chk("rst_rts", 32'(rts), 1);
      chk("rst_ferr", 32'(ferr), 0);
      chk("rst_ovr", 32'(ovr), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      u_if.ready_i = 1'b1;
      send_cap(8'hA5, got, lat);
      chk("a5_data", 32'(got), 'hA5);
      chk("a5_lat", 32'(lat), 32'(97 + MAJ));

      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_valid", 32'(u_if.valid_o), 0);
      send_cap(8'h3C, got, lat);
      chk("3c_data", 32'(got), 'h3C);

      nf = 0;
      nv = 0;
      fork
         send(8'h55, 20, 1'b0);
         for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (ferr) nf++;
            if (u_if.valid_o) nv++;
         end
      join
      chk("ferr_pulses", 32'(nf), 1);
      chk("ferr_nopush", 32'(nv), 0);
      send_cap(8'h12, got, lat);
      chk("12_data", 32'(got), 'h12);

      u_if.ready_i = 1'b0;
      send(8'h01, DIV, 1'b1);
      send(8'h02, DIV, 1'b1);
      chk("rts_after2", 32'(rts), 1);
      send(8'h03, DIV, 1'b1);
      chk("rts_after3", 32'(rts), 0);
      send(8'h04, DIV, 1'b1);
      chk("ovr_after4", 32'(ovr), 0);
      send(8'h05, DIV, 1'b1);
      chk("ovr_after5", 32'(ovr), 1);
      pop_chk("rd1", 8'h01);
      pop_chk("rd2", 8'h02);
      pop_chk("rd3", 8'h03);
      pop_chk("rd4", 8'h04);
      chk("drained", 32'(u_if.valid_o), 0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovr_clr", 32'(ovr), 0);

      for (int k = 0; k < 4; k++) send(8'(8'h10 + k), DIV, 1'b1);
      chk("full_rts", 32'(rts), 0);
      fork
         send(8'h77, DIV, 1'b1);
         begin
            repeat (97 + MAJ) @(negedge clk);
            u_if.ready_i = 1'b1;
            @(negedge clk);
            u_if.ready_i = 1'b0;
         end
      join
      chk("same_cycle_ovr", 32'(ovr), 0);
      pop_chk("sc1", 8'h11);
      pop_chk("sc2", 8'h12);
      pop_chk("sc3", 8'h13);
      pop_chk("sc4", 8'h77);

      send(8'h5A, DIV, 1'b1);
      chk("pre_rst_valid", 32'(u_if.valid_o), 1);
      fork
         send(8'hFF, DIV, 1'b1);
         begin
            repeat (54) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("mid_rst_valid", 32'(u_if.valid_o), 0);
            chk("mid_rst_data", 32'(u_if.data_o), 0);
            chk("mid_rst_rts", 32'(rts), 1);
            chk("mid_rst_ferr", 32'(ferr), 0);
            chk("mid_rst_ovr", 32'(ovr), 0);
         end
      join
      chk("ff_dropped", 32'(u_if.valid_o), 0);
      u_if.ready_i = 1'b1;
      send_cap(8'h81, got, lat);
      chk("81_data", 32'(got), 'h81);

`ifdef IOB_UART_RX_MAJORITY_EN
      fork
         send(8'h00, DIV, 1'b1);
         watch(got, lat);
         begin
            repeat (35) @(negedge clk);
            rxd = 1'b1;
            @(negedge clk);
            rxd = 1'b0;
         end
      join
      chk("maj_data", 32'(got), 0);
`endif

      done = 1'b0;
      fork
         begin
            for (int k = 0; k < 25; k++) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               send(8'($urandom), DIV, 1'b1);
            end
            done = 1'b1;
         end
         while (!done) begin
            @(negedge clk);
            u_if.ready_i = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 99) < 3);
         end
      join
      clr = 1'b0;
      u_if.ready_i = 1'b1;
      repeat (10) @(negedge clk);
      chk("final_empty", 32'(u_if.valid_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/iob_uart_rx_frontend.md
Name: iob_uart_rx_frontend

Overview:
- UART receive front-end on the board-level rxd line, directly upstream of the system's rs232 receive path.
- Synchronises rxd_i, detects and validates start bits, deserialises 8N1 frames at a fixed baud, and buffers bytes in a small FIFO with a valid/ready output.
- Drives an rts_o flow-control flag and reports framing and overrun errors, so the tester and system see clean, handshaked bytes instead of a raw asynchronous pin.

Parameters:
- FREQ, 100000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_W, 2, log2 of FIFO depth (depth = 2^FIFO_W = 4).
- Derived, not overridable: DIV = (FREQ + BAUD/2)/BAUD, clocks per bit. Counter width = $clog2(DIV+1).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; synchronous, active-high
- rxd_i  input  1  asynchronous serial line; idle high
- data_o  output  8  byte at FIFO head
- valid_o  output  1  FIFO non-empty
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i
- rts_o  output  1  1 = room available: FIFO level < 2^FIFO_W - 1
- frame_err_o  output  1  one-cycle pulse on bad stop bit
- overrun_o  output  1  sticky: byte dropped because FIFO was full
- clr_i  input  1  clears overrun_o

Behaviour:
- Reset, rst_i sampled high on a clk_i edge:
  - 2-flop synchroniser set to 1; FSM to IDLE; counters 0; FIFO empty.
  - Outputs: valid_o=0, data_o=0, rts_o=1, frame_err_o=0, overrun_o=0.
  - rst_i mid-frame aborts the frame; the partial byte is discarded.
- rx = 2nd synchroniser stage. Input-to-rx latency: 2 cycles.
- FSM states:
  - IDLE: on rx==0, go to START; bit counter cnt=0.
  - START: after DIV/2 cycles, sample rx. If 0, go to DATA with cnt=0 and bit index=0. If 1, this is a false start: return to IDLE with no error.
  - DATA: every DIV cycles, sample rx into shift register, LSB first. After bit 7, go to STOP.
  - STOP: after DIV cycles, sample rx.
    - 1: push byte (subject to FIFO rules), go to IDLE.
    - 0: frame_err_o=1 for exactly one cycle, byte discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx==1 (break/line-low condition), then IDLE. No further errors are reported while waiting.
- Sample point is the bit centre: DIV/2 after the start edge, then DIV apart.
- The push fires in the cycle the stop bit is sampled. A byte is visible on valid_o the next cycle.
- FIFO:
  - Circular buffer with read/write pointers of FIFO_W bits plus a level counter of FIFO_W+1 bits.
  - Pointers wrap modulo 2^FIFO_W.
  - Pop when valid_o && ready_i. data_o is the registered head and is stable while valid_o && !ready_i.
  - Push while full and no pop that cycle: byte dropped, overrun_o set to 1.
  - Push while full with a simultaneous pop: push accepted, level unchanged, no overrun.
  - Push and pop together on an empty FIFO never happens, because valid_o=0.
  - overrun_o stays set until clr_i=1. If clr_i and a new overrun occur in the same cycle, set wins.
- rts_o is combinational from the level: 0 when level >= 2^FIFO_W - 1.

Optional Feature:
- Macro: IOB_UART_RX_MAJORITY_EN.
- Defined: every sample (start, data, stop) is a 2-of-3 majority of rx taken at the centre-1, centre and centre+1 cycles. The decision is registered at centre+1, so sampling and the push are one cycle later than without the macro. Requires DIV >= 4; elaboration error otherwise.
- Undefined: a single sample at the centre cycle only.

Test Plan (FREQ=1000000, BAUD=100000, so DIV=10; FIFO_W=2):
- Send 0xA5 (8N1) with ready_i=1 -> valid_o high with data_o=0xA5 for 1 cycle, 2 + 95 cycles (+1 with the macro) after the start-bit falling edge; frame_err_o stays 0.
- Low glitch of 3 cycles on rxd_i, then idle -> no valid_o and no frame_err_o; FSM back in IDLE; a following 0x3C is received correctly.
- Send 0x55 with stop bit held 0 for 20 cycles, then high -> frame_err_o single pulse at the stop sample; no byte pushed; a next byte 0x12 is received correctly.
- ready_i=0, send 0x01..0x05 -> rts_o drops after the 3rd byte, FIFO holds 0x01..0x04, overrun_o=1 after the 5th. Then ready_i=1 -> reads 0x01,0x02,0x03,0x04 in order. clr_i pulse -> overrun_o=0.
- FIFO full, ready_i=1 on the exact cycle a 5th byte 0x77 is pushed -> no overrun, and 0x77 is read 4th after the current head.
- Assert rst_i during DATA bit 4 of 0xFF -> all outputs at reset values next cycle; no byte pushed; a subsequent byte 0x81 is received correctly.
- With IOB_UART_RX_MAJORITY_EN: inject a 1-cycle high glitch at the centre of bit 2 of 0x00 -> data_o=0x00.
